// File: rtl/wb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// wb_cmd_master_if : command, response and pipelined Wishbone master bundle
// Revision: 1.0
// ============================================================================
interface wb_cmd_master_if #(
  parameter int G_ADDR_WIDTH = 8
) ();
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_we_i;
  logic [G_ADDR_WIDTH-1:0] cmd_adr_i;
  logic [31:0]             cmd_dat_i;
  logic [3:0]              cmd_sel_i;

  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [31:0]             rsp_dat_o;
  logic                    rsp_err_o;
  logic                    rsp_tmo_o;

  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [G_ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]              wb_sel_o;
  logic [31:0]             wb_dat_o;
  logic [31:0]             wb_dat_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_rty_i;
  logic                    wb_stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// wb_cmd_master : one-outstanding command to pipelined Wishbone master with
//                 bus timeout and buffered response.
// Revision: 1.0
// ============================================================================
module wb_cmd_master #(
  parameter int G_ADDR_WIDTH = 8,
  parameter int G_TIMEOUT    = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  // Timeout fires on the edge where the count would reach G_TIMEOUT.
  localparam logic [15:0] C_TMO_LAST = 16'(G_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [G_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]             dat_q, dat_d;
  logic [3:0]              sel_q, sel_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [31:0]             rsp_dat_q, rsp_dat_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_tmo_q, rsp_tmo_d;

  logic                    cmd_ready;
  logic                    term;
  logic                    bus_busy;

  assign cmd_ready = (state_q == S_IDLE) && !rst_i;
  assign term      = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;
  assign bus_busy  = (state_q == S_REQ) || (state_q == S_WAIT);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    rsp_tmo_d = rsp_tmo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i && cmd_ready) begin
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
          cnt_d   = 16'd0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A termination sampled on the timeout edge still wins.
        if (term) begin
          state_d   = S_RSP;
          rsp_err_d = !bus.wb_ack_i;
          rsp_tmo_d = 1'b0;
          rsp_dat_d = (bus.wb_ack_i && !we_q) ? bus.wb_dat_i : 32'd0;
        end else if (cnt_q == C_TMO_LAST) begin
          state_d   = S_RSP;
          rsp_err_d = 1'b1;
          rsp_tmo_d = 1'b1;
          rsp_dat_d = 32'd0;
        end else if ((state_q == S_REQ) && !bus.wb_stall_i) begin
          state_d = S_WAIT;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      cnt_q     <= 16'd0;
      rsp_dat_q <= 32'd0;
      rsp_err_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rsp_tmo_q <= rsp_tmo_d;
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.wb_cyc_o    = bus_busy;
  assign bus.wb_stb_o    = (state_q == S_REQ);
  assign bus.wb_we_o     = we_q & bus_busy;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.rsp_valid_o = (state_q == S_RSP);
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_tmo_o   = rsp_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_wb_cmd_master : table-driven and randomized checks of wb_cmd_master
// Revision: 1.0
// ============================================================================
module tb_wb_cmd_master;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_master_if #(.G_ADDR_WIDTH(8)) bus ();

  wb_cmd_master #(.G_ADDR_WIDTH(8), .G_TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // kind: 0 ack, 1 err, 2 rty, 3 ack+err. term_at: bus cycle (1-based) of termination, 0 = never.
  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall;
    int          term_at;
    int          kind;
    logic [31:0] rd;
    int          rdy_dly;
    bit          late_ack;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  vec_t tbl[10];
  int   checks   = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_slave();
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
    bus.wb_rty_i   = 1'b0;
    bus.wb_stall_i = 1'b0;
    bus.wb_dat_i   = $urandom;
  endtask

  // Transaction-level reference: outcome follows from when the slave answers vs. the timeout.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.term_at != 0 && v.term_at <= T) begin
      r.exp_lat = v.term_at + 1;
      r.exp_stb = (v.stall + 1 < v.term_at) ? v.stall + 1 : v.term_at;
      r.exp_tmo = 1'b0;
      if (v.kind == 0 || v.kind == 3) begin
        r.exp_err = 1'b0;
        r.exp_dat = v.we ? 32'd0 : v.rd;
      end else begin
        r.exp_err = 1'b1;
        r.exp_dat = 32'd0;
      end
    end else begin
      r.exp_lat = T + 1;
      r.exp_stb = (v.stall + 1 < T) ? v.stall + 1 : T;
      r.exp_err = 1'b1;
      r.exp_tmo = 1'b1;
      r.exp_dat = 32'd0;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    int          lat  = 0;
    int          ncyc = 0;
    int          nstb = 0;
    int          bad  = 0;
    int          bad2 = 0;
    bit          hit;
    logic [31:0] hd;
    logic        he, ht;
    chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = v.we;
    bus.cmd_adr_i   = v.adr;
    bus.cmd_dat_i   = v.dat;
    bus.cmd_sel_i   = v.sel;
    step();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'($urandom);
    bus.cmd_adr_i   = 8'($urandom);
    bus.cmd_dat_i   = $urandom;
    bus.cmd_sel_i   = 4'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (bus.rsp_valid_o) begin
        lat = c;
        break;
      end
      if (bus.wb_cyc_o) ncyc++;
      if (bus.wb_stb_o) begin
        nstb++;
        if (bus.wb_adr_o !== v.adr || bus.wb_dat_o !== v.dat ||
            bus.wb_sel_o !== v.sel || bus.wb_we_o !== v.we) bad++;
      end
      if (bus.cmd_ready_o) bad++;
      hit            = (v.term_at == c);
      bus.wb_stall_i = (c <= v.stall);
      bus.wb_ack_i   = hit && (v.kind == 0 || v.kind == 3);
      bus.wb_err_i   = hit && (v.kind == 1 || v.kind == 3);
      bus.wb_rty_i   = hit && (v.kind == 2);
      bus.wb_dat_i   = hit ? v.rd : $urandom;
      step();
    end
    idle_slave();
    chk("rsp_latency", 32'(lat), 32'(v.exp_lat));
    chk("cyc_cycles", 32'(ncyc), 32'(v.exp_lat - 1));
    chk("stb_cycles", 32'(nstb), 32'(v.exp_stb));
    chk("bus_fields", 32'(bad), 32'd0);
    chk("rsp_dat", bus.rsp_dat_o, v.exp_dat);
    chk("rsp_err", 32'(bus.rsp_err_o), 32'(v.exp_err));
    chk("rsp_tmo", 32'(bus.rsp_tmo_o), 32'(v.exp_tmo));
    hd = bus.rsp_dat_o;
    he = bus.rsp_err_o;
    ht = bus.rsp_tmo_o;
    for (int d = 0; d < v.rdy_dly; d++) begin
      if (!bus.rsp_valid_o || bus.cmd_ready_o || bus.wb_cyc_o || bus.rsp_dat_o !== hd ||
          bus.rsp_err_o !== he || bus.rsp_tmo_o !== ht) bad2++;
      bus.wb_ack_i = v.late_ack && (d == 1);
      bus.wb_dat_i = $urandom;
      step();
    end
    bus.wb_ack_i    = 1'b0;
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk("rsp_hold", 32'(bad2), 32'd0);
    chk("rsp_release", 32'({bus.rsp_valid_o, bus.cmd_ready_o}), 32'd1);
  endtask

  initial begin
    //          we    adr    dat            sel  stl trm knd rd             dly late  exp_dat        err   tmo   lat stb
    tbl[0] = '{1'b1, 8'h00, 32'h0000_0ABC, 4'hF, 0, 2, 0, 32'h5555_5555, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 3, 1};
    tbl[1] = '{1'b0, 8'h00, 32'h0000_0000, 4'hF, 0, 2, 0, 32'h0000_0712, 1, 1'b0, 32'h0000_0712, 1'b0, 1'b0, 3, 1};
    tbl[2] = '{1'b0, 8'h05, 32'h1357_9BDF, 4'h3, 4, 6, 0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 7, 5};
    tbl[3] = '{1'b0, 8'h10, 32'h0000_0000, 4'hF, 0, 0, 0, 32'h0000_0000, 4, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 9, 1};
    tbl[4] = '{1'b0, 8'h22, 32'h0000_0000, 4'hF, 0, 2, 0, 32'hABCD_0001, 0, 1'b0, 32'hABCD_0001, 1'b0, 1'b0, 3, 1};
    tbl[5] = '{1'b0, 8'h33, 32'h0000_0000, 4'hF, 0, 2, 1, 32'hFFFF_FFFF, 5, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 3, 1};
    tbl[6] = '{1'b1, 8'h44, 32'hA5A5_5A5A, 4'h1, 0, 3, 2, 32'h1111_1111, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, 1};
    tbl[7] = '{1'b0, 8'h55, 32'h0000_0000, 4'hF, 0, 2, 3, 32'h0000_1234, 0, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 3, 1};
    tbl[8] = '{1'b0, 8'h66, 32'h0000_0000, 4'hC, 2, 8, 0, 32'h0000_CAFE, 2, 1'b0, 32'h0000_CAFE, 1'b0, 1'b0, 9, 3};
    tbl[9] = '{1'b0, 8'h77, 32'h0000_0000, 4'hF, 0, 1, 0, 32'h8765_4321, 0, 1'b0, 32'h8765_4321, 1'b0, 1'b0, 2, 1};

    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 8'h00;
    bus.cmd_dat_i   = 32'd0;
    bus.cmd_sel_i   = 4'd0;
    bus.rsp_ready_i = 1'b0;
    idle_slave();

    rst = 1'b1;
    repeat (3) step();
    chk("rst_ctrl", 32'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.rsp_valid_o,
                         bus.rsp_err_o, bus.rsp_tmo_o, bus.cmd_ready_o}), 32'd0);
    chk("rst_adr", 32'(bus.wb_adr_o), 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat_o, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready_after", 32'(bus.cmd_ready_o), 32'd1);

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset while the bus cycle waits for its termination.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 8'h99;
    step();
    bus.cmd_valid_i = 1'b0;
    step();
    chk("wait_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd2);
    rst = 1'b1;
    step();
    chk("rst_abort", 32'({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o, bus.cmd_ready_o}), 32'd0);
    rst          = 1'b0;
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    chk("post_rst", 32'({bus.wb_cyc_o, bus.rsp_valid_o, bus.cmd_ready_o}), 32'd1);
    step();
    chk("post_rst_no_rsp", 32'({bus.rsp_valid_o, bus.cmd_ready_o}), 32'd1);
    run_txn(tbl[1]);

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v          = tbl[0];
      v.we       = 1'($urandom);
      v.adr      = 8'($urandom);
      v.dat      = $urandom;
      v.sel      = 4'($urandom);
      v.stall    = $urandom_range(0, 4);
      v.term_at  = ($urandom_range(0, 5) == 0) ? 0 : v.stall + 1 + $urandom_range(0, 5);
      v.kind     = $urandom_range(0, 3);
      v.rd       = $urandom;
      v.rdy_dly  = $urandom_range(0, 3);
      v.late_ack = 1'b0;
      run_txn(model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
